rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single synchronous pattern/envelope ROM between NUM_CH channel controllers.
- Each controller raises a level request with a ROM address. The arbiter grants one requester at a time in round-robin order, issues the ROM read, and captures the ROM data. It then returns that data to the winner with a one-cycle valid pulse.
- Sits between the channel controllers' ROM-source muxes and the ROM read port in the APU top level.

Parameters:
- NUM_CH, 4, number of requesting channels (>=2).
- ADDR_WIDTH, 10, ROM address width.
- DATA_WIDTH, 16, ROM data width.
- ROM_LATENCY, 1, cycles from o_rom_en to valid i_rom_data (>=1).

Ports:
- i_clk  in  1  clock; the block uses one clock only.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  NUM_CH  level request per channel; held until that channel's o_valid.
- i_addr  in  NUM_CH*ADDR_WIDTH  request address; channel k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- o_grant  out  NUM_CH  one-hot current owner; all-zero when idle.
- o_valid  out  NUM_CH  one-cycle pulse on the winner's bit; o_data is valid in that cycle.
- o_data  out  DATA_WIDTH  captured ROM word, shared by all channels.
- o_rom_en  out  1  ROM read enable, one-cycle pulse.
- o_rom_addr  out  ADDR_WIDTH  ROM read address.
- i_rom_data  in  DATA_WIDTH  ROM read data.
- o_busy  out  1  high when state != IDLE.

Behaviour:
- Reset: asserting i_rst_n low immediately forces the following, independent of the clock:
  - state = IDLE, round-robin pointer ptr = 0, latency counter = 0;
  - o_grant, o_valid, o_data, o_rom_en, o_rom_addr = 0.
- States and transitions:
  - IDLE: if any i_req bit is set, choose the winner as the first set bit searching ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1. Latch the winner's i_addr into o_rom_addr and set o_grant to the winner. Go to ISSUE. If no request, stay in IDLE.
  - ISSUE: o_rom_en = 1 for this single cycle; load the counter with ROM_LATENCY-1. Go to WAIT.
  - WAIT: if counter == 0, capture i_rom_data into o_data and go to RESPOND. Otherwise decrement the counter and stay in WAIT.
  - RESPOND: o_valid[winner] = 1; ptr = winner+1, wrapping NUM_CH-1 -> 0. Go to IDLE; o_grant clears on entering IDLE.
- All outputs are registered.
- o_grant is held from ISSUE through RESPOND.
- o_rom_addr and o_data hold their last values until the next latch or capture.
- Latency, with requests sampled in IDLE at cycle 0:
  - rom_en at cycle 1;
  - o_valid at cycle 2+ROM_LATENCY;
  - next arbitration (IDLE) at cycle 3+ROM_LATENCY.
  - A transaction therefore occupies 3+ROM_LATENCY cycles; ROM_LATENCY=1 gives 4 cycles.
- Handshake rule: a requester must clear i_req on the clock edge ending its o_valid cycle. It therefore reads 0 in the following IDLE and is not re-granted spuriously. A requester may re-raise i_req one cycle later.
- Boundary conditions:
  - Changes to i_addr after the grant are ignored; the address is latched in IDLE.
  - If i_req drops mid-transaction, the transaction still completes and o_valid still pulses.
  - Simultaneous requests are served strictly round-robin; no channel waits more than NUM_CH-1 transactions.
  - A request arriving during a busy transaction waits for the next IDLE.
  - Reset asserted mid-transaction aborts it with no o_valid. Requests still held after release are arbitrated from ptr = 0.
  - The first arbitration happens no earlier than the first clock edge after reset release.

Test Plan:
- Single request, ROM_LATENCY=1: ch2 requests addr 0x05A, ROM model returns 0x1234 -> o_rom_en with o_rom_addr 0x05A at cycle 1; o_grant=0100 for cycles 1-3; o_valid=0100 and o_data=0x1234 at cycle 3; o_busy low at cycle 4.
- All four channels request at cycle 0 after reset -> service order ch0,ch1,ch2,ch3; o_valid pulses at cycles 3,7,11,15 with correct per-channel data; never more than one o_valid bit set.
- Fairness: ch0 re-requests continuously with ch3 also pending -> grants alternate 0,3,0,3; ch3 is never starved.
- Wrap: after ch3 is served (ptr wraps to 0), ch0 and ch1 request together -> ch0 wins, then ch1.
- ROM_LATENCY=3: single request -> o_valid at cycle 5; o_data equals the word the ROM model drives 3 cycles after o_rom_en; a stale word shown earlier is not captured.
- Async reset during WAIT -> all outputs 0 without a clock edge, no o_valid; after release, the held ch1 request completes a normal transaction starting from ptr=0.

Source files
------------

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port between NUM_CH requesters.
// Each grant issues one ROM read, captures the word after ROM_LATENCY cycles and pulses o_valid.
module rom_arbiter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_CH-1:0]            i_req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_addr,
    output logic [NUM_CH-1:0]            o_grant,
    output logic [NUM_CH-1:0]            o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_rom_en,
    output logic [ADDR_WIDTH-1:0]        o_rom_addr,
    input  logic [DATA_WIDTH-1:0]        i_rom_data,
    output logic                         o_busy
);

    localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CntW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

    state_e                  state_q, state_d;
    logic [PtrW-1:0]         ptr_q, ptr_d;
    logic [PtrW-1:0]         win_q, win_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [NUM_CH-1:0]       grant_q, grant_d;
    logic [NUM_CH-1:0]       valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    rom_en_q, rom_en_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic                    busy_q, busy_d;

    logic                    found;
    logic [PtrW-1:0]         pick;

    // First set request searching upward from ptr_q with wrap-around.
    always_comb begin
        int unsigned     idx;
        logic [PtrW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            cand = PtrW'(idx);
            if (!found && i_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (found) state_d = StIssue;
            StIssue:   state_d = StWait;
            StWait:    if (cnt_q == '0) state_d = StRespond;
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        valid_d    = '0;
        data_d     = data_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    win_d      = pick;
                    grant_d    = {{(NUM_CH-1){1'b0}}, 1'b1} << pick;
                    rom_addr_d = i_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    rom_en_d   = 1'b1;
                end
            end
            StIssue: cnt_d = CntW'(ROM_LATENCY - 1);
            StWait: begin
                if (cnt_q == '0) begin
                    data_d  = i_rom_data;
                    valid_d = grant_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRespond: begin
                ptr_d   = (win_q == PtrW'(NUM_CH - 1)) ? '0 : win_q + 1'b1;
                grant_d = '0;
            end
            default: ;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q      <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            valid_q    <= '0;
            data_q     <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            busy_q     <= busy_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_rom_en   = rom_en_q;
    assign o_rom_addr = rom_addr_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed stimulus with a response queue per DUT drained by a monitor.
// Two instances cover ROM_LATENCY=1 and ROM_LATENCY=3.
module tb_rom_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req1, req3;
    logic [39:0] addr1, addr3;
    logic [3:0]  g1, v1, g3, v3;
    logic [15:0] d1, d3, rd1, rd3;
    logic        en1, en3, busy1, busy3;
    logic [9:0]  a1, a3;

    rom_arbiter #(.NUM_CH(4), .ADDR_WIDTH(10), .DATA_WIDTH(16), .ROM_LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_addr(addr1), .o_grant(g1),
        .o_valid(v1), .o_data(d1), .o_rom_en(en1), .o_rom_addr(a1), .i_rom_data(rd1),
        .o_busy(busy1)
    );

    rom_arbiter #(.NUM_CH(4), .ADDR_WIDTH(10), .DATA_WIDTH(16), .ROM_LATENCY(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req3), .i_addr(addr3), .o_grant(g3),
        .o_valid(v3), .o_data(d3), .o_rom_en(en3), .o_rom_addr(a3), .i_rom_data(rd3),
        .o_busy(busy3)
    );

    // ROM models: word appears exactly LATENCY cycles after rom_en, 0xDEAD otherwise.
    function automatic logic [15:0] rom_word(input logic [9:0] a);
        return 16'h11DA + 16'(a);
    endfunction

    logic       p1 = 1'b0;
    logic [9:0] pa1 = '0;
    logic [2:0] p3 = '0;
    logic [9:0] pa3_0 = '0, pa3_1 = '0, pa3_2 = '0;

    always @(posedge clk) begin
        p1    <= en1;
        pa1   <= a1;
        p3    <= {p3[1:0], en3};
        pa3_0 <= a3;
        pa3_1 <= pa3_0;
        pa3_2 <= pa3_1;
    end

    assign rd1 = p1 ? rom_word(pa1) : 16'hDEAD;
    assign rd3 = p3[2] ? rom_word(pa3_2) : 16'hDEAD;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0]  ch;
        logic [15:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    task automatic exp1(input logic [3:0] ch, input logic [15:0] data);
        q1.push_back({ch, data});
    endtask

    always @(negedge clk) begin
        if (v1 != 4'b0) begin
            check("v1_onehot", $countones(v1), 1);
            check("v1_grant", g1, v1);
            if (q1.size() == 0) begin
                check("v1_unexpected", v1, 0);
            end else begin
                e1 = q1.pop_front();
                check("v1_channel", v1, e1.ch);
                check("v1_data", d1, e1.data);
            end
        end
        if (v3 != 4'b0) begin
            check("v3_onehot", $countones(v3), 1);
            if (q3.size() == 0) begin
                check("v3_unexpected", v3, 0);
            end else begin
                e3 = q3.pop_front();
                check("v3_channel", v3, e3.ch);
                check("v3_data", d3, e3.data);
            end
        end
    end

    // Requester model: drop i_req on the edge ending o_valid, optionally re-raise a cycle later.
    logic [3:0] raise1 = '0;
    int         left1[4];

    task automatic step();
        logic [3:0] vm1, vm3;
        @(negedge clk);
        vm1 = v1;
        vm3 = v3;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (raise1[k] && left1[k] > 0) begin
                req1[k] = 1'b1;
                left1[k] = left1[k] - 1;
            end
        end
        raise1 = vm1;
        req1 = req1 & ~vm1;
        req3 = req3 & ~vm3;
    endtask

    task automatic chk_zero1(input string tag);
        check({tag, "_grant"}, g1, 0);
        check({tag, "_valid"}, v1, 0);
        check({tag, "_data"}, d1, 0);
        check({tag, "_rom_en"}, en1, 0);
        check({tag, "_rom_addr"}, a1, 0);
        check({tag, "_busy"}, busy1, 0);
    endtask

    initial begin
        req1 = '0;
        req3 = '0;
        addr1 = '0;
        addr3 = '0;
        for (int k = 0; k < 4; k++) left1[k] = 0;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk_zero1("rst");
        check("rst3_grant", g3, 0);
        check("rst3_busy", busy3, 0);
        check("rst3_rom_en", en3, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // T1: single request ch2, addr 0x05A -> 0x1234.
        addr1[20 +: 10] = 10'h05A;
        req1[2] = 1'b1;
        exp1(4'b0100, 16'h1234);
        #3;
        check("t1_c0_busy", busy1, 0);
        check("t1_c0_grant", g1, 0);
        step(); #3;
        check("t1_c1_rom_en", en1, 1);
        check("t1_c1_rom_addr", a1, 10'h05A);
        check("t1_c1_grant", g1, 4'b0100);
        check("t1_c1_busy", busy1, 1);
        addr1[20 +: 10] = 10'h3FF;
        step(); #3;
        check("t1_c2_rom_en", en1, 0);
        check("t1_c2_grant", g1, 4'b0100);
        check("t1_c2_valid", v1, 0);
        step(); #3;
        check("t1_c3_grant", g1, 4'b0100);
        check("t1_c3_valid", v1, 4'b0100);
        step(); #3;
        check("t1_c4_busy", busy1, 0);
        check("t1_c4_grant", g1, 0);
        check("t1_c4_valid", v1, 0);
        check("t1_c4_data_hold", d1, 16'h1234);
        check("t1_c4_addr_hold", a1, 10'h05A);
        check("t1_drain", q1.size(), 0);

        // T2: all four request right after reset; served 0,1,2,3.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        addr1 = {10'h040, 10'h030, 10'h020, 10'h010};
        req1 = 4'b1111;
        exp1(4'b0001, 16'h11EA);
        exp1(4'b0010, 16'h11FA);
        exp1(4'b0100, 16'h120A);
        exp1(4'b1000, 16'h121A);
        for (int c = 0; c < 17; c++) begin
            #3;
            check("t2_valid_timing", v1, (c == 3) ? 4'b0001 : (c == 7) ? 4'b0010 :
                  (c == 11) ? 4'b0100 : (c == 15) ? 4'b1000 : 4'b0000);
            step();
        end
        check("t2_drain", q1.size(), 0);

        // T4: pointer wrapped to 0; ch0 and ch1 together -> ch0 then ch1.
        addr1[0 +: 10] = 10'h050;
        addr1[10 +: 10] = 10'h060;
        req1 = 4'b0011;
        exp1(4'b0001, 16'h122A);
        exp1(4'b0010, 16'h123A);
        for (int c = 0; c < 10; c++) step();
        check("t4_drain", q1.size(), 0);

        // T3: fairness, ch0 re-requests while ch3 pending; pointer is 2 -> 3,0,3,0.
        addr1[0 +: 10] = 10'h070;
        addr1[30 +: 10] = 10'h080;
        left1[0] = 1;
        left1[3] = 1;
        req1 = 4'b1001;
        exp1(4'b1000, 16'h125A);
        exp1(4'b0001, 16'h124A);
        exp1(4'b1000, 16'h125A);
        exp1(4'b0001, 16'h124A);
        for (int c = 0; c < 20; c++) step();
        check("t3_drain", q1.size(), 0);
        check("t3_req_idle", req1, 0);

        // T5: ROM_LATENCY=3, ch1 addr 0x05A; stale 0xDEAD must not be captured.
        addr3[10 +: 10] = 10'h05A;
        req3[1] = 1'b1;
        q3.push_back({4'b0010, 16'h1234});
        for (int c = 0; c < 8; c++) begin
            #3;
            check("t5_rom_en", en3, (c == 1) ? 1 : 0);
            check("t5_valid", v3, (c == 5) ? 4'b0010 : 4'b0000);
            step();
        end
        check("t5_drain", q3.size(), 0);
        check("t5_data_hold", d3, 16'h1234);

        // T6: move pointer to 3 via ch2, then abort a ch3 transfer in WAIT.
        addr1[20 +: 10] = 10'h030;
        req1 = 4'b0100;
        exp1(4'b0100, 16'h120A);
        for (int c = 0; c < 5; c++) step();
        check("t6_pre_drain", q1.size(), 0);
        addr1[10 +: 10] = 10'h090;
        addr1[30 +: 10] = 10'h0A0;
        req1 = 4'b1010;
        step(); #3;
        check("t6_first_grant", g1, 4'b1000);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_zero1("t6_abort");
        step();
        rst_n = 1'b1;
        exp1(4'b0010, 16'h126A);
        exp1(4'b1000, 16'h127A);
        #3;
        check("t6_c0_grant", g1, 0);
        step(); #3;
        check("t6_ptr0_grant", g1, 4'b0010);
        for (int c = 0; c < 9; c++) step();
        check("t6_drain", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
